// File: rtl/demux_scan_driver_if.sv
// Handshake and demux-drive bundle between the word source, the scan driver and the 1-to-4 demux.
interface demux_scan_driver_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       D;
  logic       S1;
  logic       S0;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_data,
    input  in_ready, D, S1, S0, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, D, S1, S0, busy, done
  );
endinterface

// File: rtl/demux_scan_driver.sv
// Serialises a 4-bit word onto the demux D input, stepping {S1,S0} through channels 0..3,
// holding each channel HOLD_CYCLES clocks and pulsing done in the last cycle of the scan.
module demux_scan_driver #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  demux_scan_driver_if.slave  bus
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(HOLD_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_data;
  logic [1:0] r_sel;
  logic [7:0] r_cnt;
  logic       r_d;
  logic       r_busy;
  logic       r_done;
  logic       r_ready;

  state_t     w_nextState;
  logic [3:0] w_nextData;
  logic [1:0] w_nextSel;
  logic [7:0] w_nextCnt;
  logic       w_scanNext;

  always_comb begin
    w_nextState = r_state;
    w_nextData  = r_data;
    w_nextSel   = r_sel;
    w_nextCnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_nextState = SCAN;
          w_nextData  = bus.in_data;
          w_nextSel   = 2'd0;
          w_nextCnt   = 8'd0;
        end
      end
      SCAN: begin
        if (r_cnt == LAST_COUNT) begin
          w_nextCnt = 8'd0;
          if (r_sel == 2'd3) begin
            w_nextState = IDLE;
            w_nextSel   = 2'd0;
          end else begin
            w_nextSel = r_sel + 2'd1;
          end
        end else begin
          w_nextCnt = r_cnt + 8'd1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign w_scanNext = (w_nextState == SCAN);

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= 4'd0;
      r_sel   <= 2'd0;
      r_cnt   <= 8'd0;
      r_d     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_data  <= w_nextData;
      r_sel   <= w_nextSel;
      r_cnt   <= w_nextCnt;
      r_d     <= w_scanNext & w_nextData[w_nextSel];
      r_busy  <= w_scanNext;
      r_ready <= ~w_scanNext;
      r_done  <= w_scanNext && (w_nextSel == 2'd3) && (w_nextCnt == LAST_COUNT);
    end
  end

  assign bus.in_ready = r_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.S1       = r_sel[1];
  assign bus.S0       = r_sel[0];
  assign bus.D        = r_d;

endmodule

// File: doc/demux_scan_driver.md
Name: demux_scan_driver

Overview:
Upstream stage for the team's 1-to-4 demultiplexer (data input D, selects S1/S0, outputs Y3..Y0). It accepts a 4-bit parallel word over a valid/ready handshake and serialises it onto D, stepping {S1,S0} through channels 0..3. Each bit therefore lands on its matching demux output Y[n]. Each channel is held for a programmable number of cycles, and a one-cycle done pulse marks the end of the scan.

Parameters:
HOLD_CYCLES, 1, clock cycles each channel select is held (legal range 1..255; 0 is illegal).

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_data is valid this cycle
in_data  input  4  word to scan; bit n is driven while {S1,S0}=n
in_ready  output  1  block can accept a word this cycle
D  output  1  serial data to demux D input
S1  output  1  demux select MSB
S0  output  1  demux select LSB
busy  output  1  scan in progress
done  output  1  one-cycle pulse in the final cycle of a scan

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, D=0, S1=0, S0=0, busy=0, done=0, in_ready=1. Internal data register = 0, sel = 0, hold counter = 0.
- Reset mid-operation: asserting rst_n low forces the reset values immediately, without waiting for a clock edge. The captured word is discarded and no done pulse is issued.
- State IDLE:
  - in_ready=1, busy=0, D=0, {S1,S0}=00, so all demux outputs are 0.
  - A rising edge with in_valid=1 captures in_data, clears sel and the hold counter, and moves to SCAN.
- State SCAN:
  - in_ready=0, busy=1.
  - {S1,S0}=sel and D=data_reg[sel]. Both are registered outputs and glitch-free.
  - The hold counter counts 0..HOLD_CYCLES-1. When it reaches HOLD_CYCLES-1, sel increments and the counter clears.
  - When sel=3 and the counter is at HOLD_CYCLES-1:
    - done=1 for that cycle only;
    - the next edge returns to IDLE, with D=0 and sel=00.
- Latency: if the word is accepted at edge k, the first channel (sel=0) is visible in the cycle after edge k.
  - The scan occupies exactly 4*HOLD_CYCLES cycles.
  - in_ready returns to 1 in the cycle after done.
- Back-to-back words: in_valid held high re-accepts at the first IDLE edge. There is exactly one IDLE cycle (D=0, sel=00) between consecutive scans.
- in_valid during SCAN is ignored: no capture and no state change. in_data is sampled only on the accepting edge.
- sel is 2 bits and never wraps mid-scan; the return to IDLE always follows sel=3.
- Counter width is 8 bits and sized for the maximum HOLD_CYCLES.
- done and busy are never both 0 while state=SCAN; done is never 1 outside SCAN.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, then release → D=0, S1S0=00, busy=0, done=0, in_ready=1. Drop rst_n asynchronously mid-cycle → outputs clear before the next edge.
2. HOLD_CYCLES=1, in_data=4'b1010 accepted at edge k → the four scan cycles show (S1S0,D) = (00,0), (01,1), (10,0), (11,1). done=1 only in the (11,1) cycle. in_ready=1 in the following cycle.
3. HOLD_CYCLES=3, in_data=4'b0110 → each select value is held 3 cycles. D = 0,0,0, 1,1,1, 1,1,1, 0,0,0. busy=1 for 12 cycles. done occurs in cycle 12 only.
4. HOLD_CYCLES=1, in_valid held high with in_data=4'b0001 then 4'b1000 → first scan D = 1,0,0,0. Then one IDLE cycle (D=0, S=00, in_ready=1) during which 4'b1000 is accepted. Second scan D = 0,0,0,1.
5. During a scan of 4'b1111, pulse in_valid with 4'b0000 at sel=1 → no effect; D stays 1 for all four channels and a single done is issued.
6. HOLD_CYCLES=2, scan of 4'b1111: assert rst_n=0 while sel=2 → immediate D=0, S=00, busy=0, no done. After release, accepting 4'b0100 restarts at sel=0 → D = 0,0, 0,0, 1,1, 0,0.
